// File: rtl/matrix_rx_loader.sv
// matrix_rx_loader
//   Parses a UART byte stream into the matrix multiplier's operand buffers.
//   The stream is a size byte N, then N*N elements of A, then N*N elements of B,
//   both row-major. After the last B element it pulses mm_start and then waits
//   for mm_done. A load is abandoned on a bad size byte or when the gap between
//   bytes grows too long.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active-high
//   rx_data   received byte
//   rx_valid  one-cycle strobe qualifying rx_data
//   mm_done   one-cycle pulse, multiplier finished
//   a_we      A buffer write enable (one cycle per element)
//   b_we      B buffer write enable (one cycle per element)
//   wr_addr   buffer address, row*MAX_N + col
//   wr_data   element value
//   mat_n     latched matrix dimension N
//   mm_start  one-cycle start pulse to the multiplier
//   busy      high whenever a load or multiply is in progress
//   err       one-cycle pulse: bad size, timeout, or byte received while waiting
module matrix_rx_loader #(
  parameter int unsigned MAX_N       = 4,
  parameter int unsigned DW          = 8,
  parameter int unsigned AW          = 4,
  parameter int unsigned NW          = 3,
  parameter int unsigned TIMEOUT_CYC = 2000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] rx_data,
  input  logic          rx_valid,
  input  logic          mm_done,
  output logic          a_we,
  output logic          b_we,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [NW-1:0] mat_n,
  output logic          mm_start,
  output logic          busy,
  output logic          err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StStart,
    StWaitMm
  } state_e;

  state_e        state_q, state_d;
  logic [NW-1:0] row_q, row_d;
  logic [NW-1:0] col_q, col_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          a_we_q, a_we_d;
  logic          b_we_q, b_we_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [NW-1:0] mat_n_q, mat_n_d;
  logic          mm_start_q, mm_start_d;
  logic          err_q, err_d;

  logic          size_ok;
  logic          last_col;
  logic          last_row;
  logic [AW-1:0] elem_addr;
  logic [TW-1:0] tcnt_inc;
  logic          timeout;

  assign size_ok   = (rx_data != '0) && (rx_data <= DW'(MAX_N));
  assign last_col  = (col_q == NW'(mat_n_q - NW'(1)));
  assign last_row  = (row_q == NW'(mat_n_q - NW'(1)));
  assign elem_addr = AW'(AW'(row_q) * AW'(MAX_N) + AW'(col_q));
  assign tcnt_inc  = TW'(tcnt_q + TW'(1));
  // Fires on the edge where the idle count would reach TIMEOUT_CYC-1.
  assign timeout   = (tcnt_inc == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_d      = col_q;
    tcnt_d     = tcnt_q;
    a_we_d     = 1'b0;
    b_we_d     = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mat_n_d    = mat_n_q;
    mm_start_d = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      StIdle: begin
        tcnt_d = '0;
        if (rx_valid) begin
          if (size_ok) begin
            mat_n_d = rx_data[NW-1:0];
            row_d   = '0;
            col_d   = '0;
            state_d = StLoadA;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      StLoadA, StLoadB: begin
        // A byte arriving on the timeout edge takes priority.
        if (rx_valid) begin
          tcnt_d    = '0;
          wr_data_d = rx_data;
          wr_addr_d = elem_addr;
          a_we_d    = (state_q == StLoadA);
          b_we_d    = (state_q == StLoadB);
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = (state_q == StLoadA) ? StLoadB : StStart;
            end else begin
              row_d = NW'(row_q + NW'(1));
            end
          end else begin
            col_d = NW'(col_q + NW'(1));
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          tcnt_d  = '0;
          state_d = StIdle;
        end else begin
          tcnt_d = tcnt_inc;
        end
      end

      // Registered pulse lands one cycle after the final b_we.
      StStart: begin
        tcnt_d     = '0;
        mm_start_d = 1'b1;
        state_d    = StWaitMm;
      end

      StWaitMm: begin
        if (rx_valid) begin
          err_d = 1'b1;
        end
        if (mm_done) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_q      <= '0;
      tcnt_q     <= '0;
      a_we_q     <= 1'b0;
      b_we_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      mat_n_q    <= '0;
      mm_start_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      tcnt_q     <= tcnt_d;
      a_we_q     <= a_we_d;
      b_we_q     <= b_we_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      mat_n_q    <= mat_n_d;
      mm_start_q <= mm_start_d;
      err_q      <= err_d;
    end
  end

  assign a_we     = a_we_q;
  assign b_we     = b_we_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign mat_n    = mat_n_q;
  assign mm_start = mm_start_q;
  assign err      = err_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_matrix_rx_loader.sv
module tb_matrix_rx_loader;

  localparam int unsigned MAX_N = 4;
  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 4;
  localparam int unsigned NW    = 3;
  localparam int unsigned TO    = 100;

  typedef logic [AW+DW:0] wr_t;  // {is_b, addr, data}

  typedef struct {
    logic [7:0]    size;
    logic          exp_err;
    logic          exp_busy;
    logic [NW-1:0] exp_n;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          mm_done;
  logic          a_we;
  logic          b_we;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NW-1:0] mat_n;
  logic          mm_start;
  logic          busy;
  logic          err;

  matrix_rx_loader #(
    .MAX_N      (MAX_N),
    .DW         (DW),
    .AW         (AW),
    .NW         (NW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .rx_data (rx_data),
    .rx_valid(rx_valid),
    .mm_done (mm_done),
    .a_we    (a_we),
    .b_we    (b_we),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mat_n   (mat_n),
    .mm_start(mm_start),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Monitor: log everything the DUT emits, sampled on the falling edge.
  wr_t got_q[$];
  wr_t exp_q[$];
  int  n_start, n_err, start_cyc, err_cyc, last_b_cyc, last_rx_cyc;

  always @(negedge clk) begin
    if (a_we) got_q.push_back({1'b0, wr_addr, wr_data});
    if (b_we) begin
      got_q.push_back({1'b1, wr_addr, wr_data});
      last_b_cyc = cyc;
    end
    if (mm_start) begin
      n_start++;
      start_cyc = cyc;
    end
    if (err) begin
      n_err++;
      err_cyc = cyc;
    end
  end

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] a_v[16];
  logic [7:0] b_v[16];
  vec_t       vt[8];

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    n_start = 0;
    n_err   = 0;
    start_cyc = -1;
    err_cyc   = -1;
    last_b_cyc = -1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_data     = b;
    rx_valid    = 1'b1;
    last_rx_cyc = cyc;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int max_gap);
    int g;
    g = (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap));
    repeat (g) step();
  endtask

  // Reference: element k of a matrix lands at row*MAX_N + col of its buffer.
  task automatic build_expect(input int n);
    exp_q.delete();
    for (int m = 0; m < 2; m++) begin
      for (int r = 0; r < n; r++) begin
        for (int c = 0; c < n; c++) begin
          logic [AW-1:0] ad;
          logic [7:0]    d;
          ad = AW'(r * MAX_N + c);
          d  = (m == 0) ? a_v[r*n+c] : b_v[r*n+c];
          exp_q.push_back({m[0], ad, d});
        end
      end
    end
  endtask

  task automatic load(input int n, input int max_gap);
    send(8'(n));
    for (int i = 0; i < n * n; i++) begin
      gap(max_gap);
      send(a_v[i]);
    end
    for (int i = 0; i < n * n; i++) begin
      gap(max_gap);
      send(b_v[i]);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int k = 0; k < 20 && n_start == 0; k++) step();
    chk({tag, " mm_start count"}, n_start, 1);
    chk({tag, " mm_start after last b_we"}, start_cyc, last_b_cyc + 1);
  endtask

  task automatic check_writes(input string tag);
    chk({tag, " write count"}, got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        chk($sformatf("%s write %0d", tag, i), got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    rx_data  = '0;
    rx_valid = 1'b0;
    mm_done  = 1'b0;
    clear_mon();
    step();
    chk("reset outputs", {a_we, b_we, wr_addr, wr_data, mat_n, mm_start, busy, err}, 0);
    rst = 1'b0;
    step();

    // Size-byte table: rejects pulse err and stay idle, accepts latch N.
    vt[0] = '{8'h00, 1'b1, 1'b0, 3'd0};
    vt[1] = '{8'h05, 1'b1, 1'b0, 3'd0};
    vt[2] = '{8'h09, 1'b1, 1'b0, 3'd0};
    vt[3] = '{8'hff, 1'b1, 1'b0, 3'd0};
    vt[4] = '{8'h01, 1'b0, 1'b1, 3'd1};
    vt[5] = '{8'h02, 1'b0, 1'b1, 3'd2};
    vt[6] = '{8'h03, 1'b0, 1'b1, 3'd3};
    vt[7] = '{8'h04, 1'b0, 1'b1, 3'd4};
    for (int i = 0; i < 8; i++) begin
      do_reset();
      clear_mon();
      send(vt[i].size);
      chk($sformatf("size %0h err", vt[i].size), err, vt[i].exp_err);
      chk($sformatf("size %0h busy", vt[i].size), busy, vt[i].exp_busy);
      chk($sformatf("size %0h mat_n", vt[i].size), mat_n, vt[i].exp_n);
      step();
      chk($sformatf("size %0h err pulses", vt[i].size), n_err, vt[i].exp_err);
      chk($sformatf("size %0h no writes", vt[i].size), got_q.size(), 0);
    end

    // Example load: N=3, fixed A and B, back-to-back bytes.
    do_reset();
    clear_mon();
    begin
      logic [7:0] ta[9];
      logic [7:0] tb[9];
      ta = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h03, 8'h04, 8'h04, 8'h03, 8'h04};
      tb = '{8'h05, 8'h06, 8'h07, 8'h08, 8'h07, 8'h08, 8'h08, 8'h07, 8'h08};
      for (int i = 0; i < 9; i++) begin
        a_v[i] = ta[i];
        b_v[i] = tb[i];
      end
    end
    build_expect(3);
    load(3, 0);
    wait_start("n3");
    check_writes("n3");
    chk("n3 mat_n", mat_n, 3);
    chk("n3 busy in wait", busy, 1);
    chk("n3 no err", n_err, 0);

    // Byte while waiting for the multiplier: err, no write.
    clear_mon();
    send(8'h11);
    chk("wait byte err", err, 1);
    chk("wait byte no write", got_q.size(), 0);
    chk("wait byte still busy", busy, 1);
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;
    chk("mm_done busy low", busy, 0);

    // Bad sizes then a good one.
    clear_mon();
    send(8'h00);
    send(8'h05);
    step();
    chk("bad sizes err count", n_err, 2);
    chk("bad sizes busy", busy, 0);
    chk("bad sizes no writes", got_q.size(), 0);
    send(8'h02);
    chk("after bad busy", busy, 1);
    chk("after bad mat_n", mat_n, 2);

    // Timeout: two A bytes then silence.
    send(8'h21);
    send(8'h22);
    clear_mon();
    for (int k = 0; k < 3 * TO && n_err == 0; k++) step();
    chk("timeout err count", n_err, 1);
    chk("timeout err cycle", err_cyc, last_rx_cyc + TO);
    chk("timeout busy", busy, 0);
    chk("timeout no start", n_start, 0);
    send(8'h02);
    chk("post-timeout busy", busy, 1);
    chk("post-timeout mat_n", mat_n, 2);

    // Longest permitted gap: byte lands on the timeout edge and wins.
    do_reset();
    clear_mon();
    a_v[0] = 8'h3c;
    b_v[0] = 8'hc3;
    build_expect(1);
    send(8'h01);
    send(a_v[0]);
    repeat (TO - 2) step();
    send(b_v[0]);
    wait_start("edge gap");
    check_writes("edge gap");
    chk("edge gap no err", n_err, 0);
    mm_done = 1'b1;
    step();
    mm_done = 1'b0;

    // Randomized loads against the reference.
    for (int it = 0; it < 12; it++) begin
      int n;
      n = int'($urandom_range(1, MAX_N));
      for (int i = 0; i < 16; i++) begin
        a_v[i] = 8'($urandom);
        b_v[i] = 8'($urandom);
      end
      clear_mon();
      build_expect(n);
      load(n, (it % 3 == 0) ? 0 : 3);
      wait_start($sformatf("rand%0d", it));
      check_writes($sformatf("rand%0d", it));
      chk($sformatf("rand%0d mat_n", it), mat_n, n);
      chk($sformatf("rand%0d no err", it), n_err, 0);
      repeat (it % 4) step();
      if (it % 2 == 1) begin
        // mm_done with a byte on the same cycle: drop the byte, flag it.
        rx_data  = 8'h5a;
        rx_valid = 1'b1;
        mm_done  = 1'b1;
        step();
        rx_valid = 1'b0;
        mm_done  = 1'b0;
        chk($sformatf("rand%0d done+byte err", it), err, 1);
      end else begin
        mm_done = 1'b1;
        step();
        mm_done = 1'b0;
        chk($sformatf("rand%0d done err", it), err, 0);
      end
      chk($sformatf("rand%0d idle after done", it), busy, 0);
      chk($sformatf("rand%0d extra writes", it), got_q.size(), exp_q.size());
    end

    // Asynchronous reset in the middle of LOAD_B.
    clear_mon();
    send(8'h02);
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i));
    send(8'h50);
    #2;
    rst = 1'b1;
    #1;
    chk("async reset outputs", {a_we, b_we, wr_addr, wr_data, mat_n, mm_start, busy, err}, 0);
    step();
    step();
    rst = 1'b0;
    step();
    clear_mon();
    a_v[0] = 8'haa;
    b_v[0] = 8'hbb;
    build_expect(1);
    load(1, 0);
    wait_start("post reset");
    check_writes("post reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
